// File: rtl/neo_frame_sequencer.sv
// NEO (nonlinear energy operator) frame sequencer: streams an M-sample frame from a sync-read RAM,
// writes the saturated psi[k] to a result RAM and counts samples whose psi exceeds a threshold.
module neo_frame_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [2*N:0]     thr,
    output logic                    busy,
    output logic                    done,
    output logic                    ren,
    output logic [$clog2(M)-1:0]    raddr,
    input  logic signed [N-1:0]     rdata,
    output logic                    wen,
    output logic [$clog2(M)-1:0]    waddr,
    output logic signed [N-1:0]     wdata,
    output logic [$clog2(M):0]      spike_cnt
);

    localparam int unsigned AW  = $clog2(M);
    localparam int unsigned CNW = AW + 1;
    localparam int unsigned CW  = $clog2(M + 5);
    localparam int unsigned QW  = 2 * N;
    localparam int unsigned PW  = 2 * N + 1;

    // Cycle-index landmarks, counted from the start-acceptance edge
    localparam logic [CW-1:0] C_RD_LAST  = CW'(M);
    localparam logic [CW-1:0] C_WR_FIRST = CW'(3);
    localparam logic [CW-1:0] C_WR_LAST  = CW'(M + 2);
    localparam logic [CW-1:0] C_IN_FIRST = CW'(4);
    localparam logic [CW-1:0] C_IN_LAST  = CW'(M + 1);
    localparam logic [CW-1:0] C_END      = CW'(M + 3);

    localparam logic signed [PW-1:0] PSI_MAX = PW'(2 ** (N - 1) - 1);
    localparam logic signed [PW-1:0] PSI_MIN = ~PSI_MAX;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cyc, cyc_nx;
    logic signed [N-1:0]    x_prev, x_cur;
    logic                   rvalid;
    logic signed [PW-1:0]   thr_q, thr_nx;
    logic [CNW-1:0]         cnt, cnt_nx;

    logic                   busy_nx, done_nx, ren_nx, wen_nx;
    logic [AW-1:0]          raddr_nx, waddr_nx;
    logic signed [N-1:0]    wdata_nx;
    logic [CNW-1:0]         spike_nx;

    logic signed [QW-1:0]   sq, cr;
    logic signed [PW-1:0]   psi;
    logic signed [N-1:0]    psi_sat;
    logic                   in_wr, in_interior;

    // psi for the next write: window {x_prev, x_cur} plus the sample arriving on rdata
    always_comb begin
        sq  = QW'(x_cur) * QW'(x_cur);
        cr  = QW'(x_prev) * QW'(rdata);
        psi = PW'(sq) - PW'(cr);
        if (psi > PSI_MAX) begin
            psi_sat = N'(PSI_MAX);
        end else if (psi < PSI_MIN) begin
            psi_sat = N'(PSI_MIN);
        end else begin
            psi_sat = N'(psi);
        end
    end

    assign in_wr       = (state == READ || state == DRAIN) && (cyc >= C_WR_FIRST) && (cyc <= C_WR_LAST);
    assign in_interior = (cyc >= C_IN_FIRST) && (cyc <= C_IN_LAST);

    always_comb begin
        state_nx = state;
        cyc_nx   = cyc;
        thr_nx   = thr_q;
        cnt_nx   = cnt;
        ren_nx   = 1'b0;
        raddr_nx = raddr;
        wen_nx   = 1'b0;
        waddr_nx = waddr;
        wdata_nx = wdata;
        done_nx  = 1'b0;
        spike_nx = spike_cnt;

        case (state)
            IDLE: begin
                cyc_nx = '0;
                if (start && !abort) begin
                    state_nx = READ;
                    cyc_nx   = CW'(1);
                    ren_nx   = 1'b1;
                    raddr_nx = '0;
                    thr_nx   = thr;
                    cnt_nx   = '0;
                end
            end
            READ: begin
                cyc_nx = cyc + CW'(1);
                if (cyc < C_RD_LAST) begin
                    ren_nx   = 1'b1;
                    raddr_nx = AW'(cyc);
                end else begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                cyc_nx = cyc + CW'(1);
                if (cyc == C_END) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    spike_nx = cnt;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cyc_nx   = '0;
            end
        endcase

        // Result writes overlap the tail of READ; boundary samples are written as zero
        if (in_wr) begin
            wen_nx   = 1'b1;
            waddr_nx = AW'(cyc - C_WR_FIRST);
            if (in_interior) begin
                wdata_nx = psi_sat;
                if (psi > thr_q) begin
                    cnt_nx = cnt + CNW'(1);
                end
            end else begin
                wdata_nx = '0;
            end
        end

        if (abort && state != IDLE) begin
            state_nx = IDLE;
            cyc_nx   = '0;
            ren_nx   = 1'b0;
            wen_nx   = 1'b0;
            done_nx  = 1'b0;
            spike_nx = spike_cnt;
        end

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cyc       <= '0;
            thr_q     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ren       <= 1'b0;
            raddr     <= '0;
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            spike_cnt <= '0;
        end else begin
            state     <= state_nx;
            cyc       <= cyc_nx;
            thr_q     <= thr_nx;
            cnt       <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            ren       <= ren_nx;
            raddr     <= raddr_nx;
            wen       <= wen_nx;
            waddr     <= waddr_nx;
            wdata     <= wdata_nx;
            spike_cnt <= spike_nx;
        end
    end

    // Sample window: rdata is valid the cycle after each read request
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            x_prev <= '0;
            x_cur  <= '0;
        end else begin
            rvalid <= ren;
            if (rvalid) begin
                x_prev <= x_cur;
                x_cur  <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Directed bench for neo_frame_sequencer (N=8, M=8) with sample/result RAM models.
module tb_neo_frame_sequencer;

    localparam int unsigned N = 8;
    localparam int unsigned M = 8;

    logic                 Clk = 1'b0;
    logic                 reset, start, abort;
    logic signed [2*N:0]  thr;
    logic                 busy, done, ren, wen;
    logic [2:0]           raddr, waddr;
    logic signed [N-1:0]  rdata, wdata;
    logic [3:0]           spike_cnt;

    logic signed [N-1:0]  mem [M];
    logic signed [N-1:0]  res [M];
    logic                 clr;
    int                   wr_count;
    int                   exp_res [M];

    int total = 0;
    int bad   = 0;
    int n_done, done_cyc, busy_cyc;
    logic [31:0] busy_log, ren_log, wen_log;

    neo_frame_sequencer #(.N(N), .M(M)) dut (
        .Clk(Clk), .reset(reset), .start(start), .abort(abort), .thr(thr),
        .busy(busy), .done(done), .ren(ren), .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata), .spike_cnt(spike_cnt)
    );

    always #5 Clk = ~Clk;

    // Sync-read sample RAM and result RAM (cleared to 0x55 so missing writes show up)
    always @(posedge Clk) begin
        if (ren) rdata <= mem[raddr];
        if (clr) begin
            res      <= '{default: 8'sh55};
            wr_count <= 0;
        end else if (wen) begin
            res[waddr] <= wdata;
            wr_count   <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_res(input string t);
        for (int i = 0; i < M; i++)
            chk($sformatf("%s res%0d", t, i), res[3'(i)], exp_res[i]);
    endtask

    // One pass; cycle c is the c-th clock period after the start-accepting edge
    task automatic run_pass(input logic signed [2*N:0] t, input int repulse,
                            input int abort_at, input int hold_until);
        @(negedge Clk);
        clr = 1'b1;
        @(negedge Clk);
        clr   = 1'b0;
        thr   = t;
        start = 1'b1;
        @(posedge Clk);
        n_done = 0; busy_cyc = 0; done_cyc = 0;
        busy_log = '0; ren_log = '0; wen_log = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            start = (c == repulse) || (c < hold_until);
            abort = (c == abort_at);
            busy_log[5'(c)] = busy;
            ren_log[5'(c)]  = ren;
            wen_log[5'(c)]  = wen;
            if (busy) busy_cyc++;
            if (done) begin
                n_done++;
                done_cyc = c;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; thr = '0; clr = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ren", ren, 0);
        chk("rst wen", wen, 0);
        chk("rst raddr", raddr, 0);
        chk("rst wdata", wdata, 0);
        chk("rst spike", spike_cnt, 0);
        reset = 1'b1;

        // 1: constant frame, psi = 0 everywhere
        for (int i = 0; i < M; i++) mem[i] = 8'sd5;
        run_pass(17'sd0, 0, 0, 0);
        exp_res = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_res("t1");
        chk("t1 done_cyc", done_cyc, 12);
        chk("t1 n_done", n_done, 1);
        chk("t1 spike", spike_cnt, 0);
        chk("t1 writes", wr_count, 8);
        chk("t1 ren c1", ren_log[1], 1);
        chk("t1 ren c9", ren_log[9], 0);
        chk("t1 wen c3", wen_log[3], 0);
        chk("t1 wen c4", wen_log[4], 1);
        chk("t1 wen c11", wen_log[11], 1);
        chk("t1 wen c12", wen_log[12], 0);

        // 2: ramp, psi = 1 in the interior
        for (int i = 0; i < M; i++) mem[i] = 8'(i);
        run_pass(17'sd0, 0, 0, 0);
        exp_res = '{0, 1, 1, 1, 1, 1, 1, 0};
        check_res("t2");
        chk("t2 spike", spike_cnt, 6);
        chk("t2 busy_cyc", busy_cyc, 12);

        // 3: positive saturation
        mem = '{8'sd0, 8'sd100, -8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        run_pass(17'sd9999, 0, 0, 0);
        exp_res = '{0, 127, 127, 0, 0, 0, 0, 0};
        check_res("t3");
        chk("t3 spike", spike_cnt, 2);

        // 4: negative saturation; psi[2] = 100*100 - 0*0 = 10000
        mem = '{8'sd100, 8'sd0, 8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        run_pass(-17'sd1, 0, 0, 0);
        exp_res = '{0, -128, 127, 0, 0, 0, 0, 0};
        check_res("t4");
        chk("t4 spike", spike_cnt, 5);

        // 5a: start re-pulsed while busy is ignored
        for (int i = 0; i < M; i++) mem[i] = 8'(i);
        run_pass(17'sd0, 3, 0, 0);
        chk("t5 n_done", n_done, 1);
        chk("t5 busy_cyc", busy_cyc, 12);
        chk("t5 spike", spike_cnt, 6);

        // 5b: start held high restarts in the IDLE cycle after done
        run_pass(17'sd0, 0, 0, 15);
        chk("t5b busy c12", busy_log[12], 1);
        chk("t5b busy c13", busy_log[13], 0);
        chk("t5b busy c14", busy_log[14], 1);
        chk("t5b n_done", n_done, 2);
        chk("t5b done_cyc", done_cyc, 25);

        // 6: abort in cycle 6
        mem = '{8'sd0, 8'sd100, -8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        run_pass(17'sd9999, 0, 6, 0);
        chk("t6 busy c6", busy_log[6], 1);
        chk("t6 busy c7", busy_log[7], 0);
        chk("t6 ren c7", ren_log[7], 0);
        chk("t6 wen c7", wen_log[7], 0);
        chk("t6 n_done", n_done, 0);
        chk("t6 spike", spike_cnt, 6);
        chk("t6 res2", res[2], 127);
        chk("t6 res3", res[3], 85);

        // start and abort together in IDLE: abort wins
        @(negedge Clk);
        start = 1'b1; abort = 1'b1;
        @(negedge Clk);
        start = 1'b0; abort = 1'b0;
        chk("sa busy", busy, 0);
        chk("sa ren", ren, 0);

        // reset asserted mid-READ
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid ren before", ren, 1);
        reset = 1'b0;
        #1;
        chk("mid busy", busy, 0);
        chk("mid ren", ren, 0);
        chk("mid raddr", raddr, 0);
        chk("mid spike", spike_cnt, 0);
        @(negedge Clk);
        reset = 1'b1;

        // full pass after reset recovery
        run_pass(17'sd9999, 0, 0, 0);
        chk("t7 done_cyc", done_cyc, 12);
        chk("t7 spike", spike_cnt, 2);
        chk("t7 res1", res[1], 127);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
